// File: rtl/prog_mem_loader.sv
// prog_mem_loader: fills program memory from a length-prefixed byte stream and holds the core meanwhile
module prog_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [31:0]       pm_wdata,
  output logic              busy,
  output logic              core_hold,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE_ST} state_t;
  state_t      state;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  nbyte;
  logic [23:0] word;
  logic        xfer;
  logic [15:0] len;
  assign rx_ready  = state inside {LEN_HI, LEN_LO, DATA};
  assign xfer      = rx_valid & rx_ready;
  assign len       = {count[15:8], rx_data};
  assign core_hold = busy;
  // Loader FSM; write port and status flags are registered on the transition into each state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      index    <= '0;
      nbyte    <= '0;
      word     <= '0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LEN_HI;
          busy  <= 1'b1;
          done  <= 1'b0;
          error <= 1'b0;
        end
        LEN_HI: if (xfer) begin
          count[15:8] <= rx_data;
          state       <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          count <= len;
          if (len == 16'd0 || {16'd0, len} > 32'(DEPTH)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            index <= '0;
            nbyte <= '0;
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          word  <= {word[15:0], rx_data};
          nbyte <= nbyte + 2'd1;
          if (nbyte == 2'd3) begin
            pm_we    <= 1'b1;
            pm_addr  <= ADDR_W'(index);
            pm_wdata <= {word, rx_data};
            state    <= WRITE;
          end
        end
        WRITE: begin
          pm_we <= 1'b0;
          if (index == count - 16'd1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE_ST;
          end else begin
            index <= index + 16'd1;
            nbyte <= '0;
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed loads checked against a byte-stream model of the expected writes
module tb_prog_mem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, pm_we, busy, core_hold, done, error;
  logic [15:0] pm_addr;
  logic [31:0] pm_wdata;
  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];
  int          nwr = 0;
  logic [15:0] last_addr = '0;
  logic [31:0] last_data = '0;

  prog_mem_loader #(.ADDR_W(16), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .busy(busy), .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every cycle: each write must be the next one the model predicts
  always @(negedge clk) if (reset) begin
    chk("core_hold", core_hold, busy);
    chk("addr_range", 32'(pm_addr < 16'd1024), 1);
    if (pm_we) begin
      chk("ready_on_write", rx_ready, 0);
      if (exp_q.size() == 0) chk("spurious_we", pm_we, 0);
      else begin
        chk("pm_addr", pm_addr, 32'(exp_q[0][47:32]));
        chk("pm_wdata", pm_wdata, exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
      nwr++;
      last_addr = pm_addr;
      last_data = pm_wdata;
    end
  end

  task automatic model(input logic [7:0] b[$], output bit bad);
    int n;
    n = {b[0], b[1]};
    bad = (n == 0) || (n > 1024);
    if (!bad)
      for (int i = 0; i < n; i++)
        exp_q.push_back({16'(i), b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit gap);
    int t = 0;
    rx_data = d;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_ready_timeout", rx_ready, 1);
    @(negedge clk);
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_load(input logic [7:0] b[$], input bit gap, input bit poke);
    bit bad;
    int t = 0;
    model(b, bad);
    do_start();
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("error_cleared", error, 0);
    for (int i = 0; i < (bad ? 2 : b.size()); i++) begin
      if (poke && i == 2) start = 1'b1;
      send(b[i], gap);
      start = 1'b0;
    end
    rx_valid = 1'b0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_drop", busy, 0);
    chk("done", done, 32'(!bad));
    chk("error", error, 32'(bad));
    chk("writes_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b[$];
    int n0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {pm_we, rx_ready, busy, core_hold, done, error, 2'b00, pm_addr, 8'h00}, 0);
      chk("reset_wdata", pm_wdata, 0);
    end
    n0 = nwr;
    b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
    run_load(b, 1'b0, 1'b0);
    chk("t2_writes", nwr - n0, 2);
    chk("t2_last_addr", 32'(last_addr), 1);
    chk("t2_last_data", last_data, 32'hAC090004);
    n0 = nwr;
    b = '{8'h00, 8'h00};
    run_load(b, 1'b0, 1'b0);
    chk("t3_no_writes", nwr - n0, 0);
    b = '{8'h04, 8'h01};
    run_load(b, 1'b0, 1'b0);
    chk("t4_no_writes", nwr - n0, 0);
    n0 = nwr;
    b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_load(b, 1'b1, 1'b1);
    chk("t5_writes", nwr - n0, 1);
    chk("t5_last_data", last_data, 32'h12345678);
    do_start();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    n0 = nwr;
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_core_hold", core_hold, 0);
    chk("t6_pm_we", pm_we, 0);
    chk("t6_done", done, 0);
    chk("t6_rx_ready", rx_ready, 0);
    rx_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_writes", nwr - n0, 0);
    b = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(b, 1'b0, 1'b0);
    chk("t6_fresh_data", last_data, 32'hDEADBEEF);
    b = '{8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      b.push_back(8'(i));
      b.push_back(8'(i >> 8));
      b.push_back(8'hA5);
      b.push_back(8'(~i));
    end
    n0 = nwr;
    run_load(b, 1'b0, 1'b0);
    chk("max_writes", nwr - n0, 1024);
    chk("max_last_addr", 32'(last_addr), 1023);
    chk("max_last_data", last_data, 32'hFF03A500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
